// File: rtl/aoi22_pipe_if.sv
// Valid/ready bus for the pipelined 2-2 complex-gate evaluator: operands and
// function select in, result and completed-transaction count out.
interface aoi22_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [CNTW-1:0]  cnt;

    modport master (
        output a, b, c, d, mode, in_valid, out_ready,
        input  in_ready, y, out_valid, cnt
    );

    modport slave (
        input  a, b, c, d, mode, in_valid, out_ready,
        output in_ready, y, out_valid, cnt
    );
endinterface

// File: rtl/aoi22_pipe.sv
// WIDTH-bit vector of AOI22/OAI22/AO22/OA22 gates followed by DEPTH elastic
// register stages with valid/ready flow control and an output-transfer counter.
module aoi22_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input logic         clk,
    input logic         rst_n,
    aoi22_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_AOI22 = 2'b00,
        MODE_OAI22 = 2'b01,
        MODE_AO22  = 2'b10,
        MODE_OA22  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] func_y;
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] load;
    logic [CNTW-1:0]  cnt_q;

    always_comb begin
        // NOTE: every always_comb output gets a default before the case so no latch is inferred.
        func_y = '0;
        case (mode_e'(bus.mode))
            MODE_AOI22: func_y = ~((bus.a & bus.b) | (bus.c & bus.d));
            MODE_OAI22: func_y = ~((bus.a | bus.b) & (bus.c | bus.d));
            MODE_AO22:  func_y =  (bus.a & bus.b) | (bus.c & bus.d);
            MODE_OA22:  func_y =  (bus.a | bus.b) & (bus.c | bus.d);
            default:    func_y = '0;
        endcase
    end

    // A stage may load when it is empty or its content moves on this cycle;
    // the chain is resolved from the output back to the input.
    always_comb begin
        logic rdy;
        load = '0;
        rdy  = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            load[k] = !stage_valid[k] || rdy;
            rdy     = load[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments; the data array is
            // reset too because the result bus must read zero while in reset.
            stage_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (load[0]) begin
                stage_valid[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    stage_data[0] <= func_y;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    stage_valid[k] <= stage_valid[k-1];
                    if (stage_valid[k-1]) begin
                        stage_data[k] <= stage_data[k-1];
                    end
                end
            end
            if (stage_valid[DEPTH-1] && bus.out_ready) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.y         = stage_data[DEPTH-1];
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.cnt       = cnt_q;
endmodule

// File: tb/tb_aoi22_pipe.sv
// Directed bench for aoi22_pipe: one 8-bit/2-stage/4-bit-counter instance and
// one 16-bit/1-stage instance for the per-bit gate coverage.
module tb_aoi22_pipe;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    aoi22_pipe_if #(.WIDTH(8),  .CNTW(4))  ifc0 ();
    aoi22_pipe_if #(.WIDTH(16), .CNTW(16)) ifc1 ();

    aoi22_pipe #(.WIDTH(8), .DEPTH(2), .CNTW(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0.slave)
    );

    aoi22_pipe #(.WIDTH(16), .DEPTH(1), .CNTW(16)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exh_exp [4] = '{16'h0777, 16'h111F, 16'hF888, 16'hEEE0};
    logic [7:0]  tt_exp  [4] = '{8'h35, 8'h53, 8'hCA, 8'hAC};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [1:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        ifc0.in_valid = v;
        ifc0.mode     = m;
        ifc0.a        = a;
        ifc0.b        = b;
        ifc0.c        = c;
        ifc0.d        = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive0(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        ifc0.out_ready = 1'b1;
        ifc1.in_valid  = 1'b0;
        ifc1.mode      = 2'b00;
        ifc1.a         = '0;
        ifc1.b         = '0;
        ifc1.c         = '0;
        ifc1.d         = '0;
        ifc1.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", 32'(ifc0.out_valid), 32'd0);
        check("rst_y",         32'(ifc0.y),         32'd0);
        check("rst_cnt",       32'(ifc0.cnt),       32'd0);
        check("rst_in_ready",  32'(ifc0.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table, four modes back-to-back, two-stage latency
        for (int m = 0; m < 4; m++) begin
            drive0(1'b1, 2'(m), 8'hF0, 8'hCC, 8'h0F, 8'hAA);
            @(negedge clk);
            if (m == 0) check("tt_latency_ov", 32'(ifc0.out_valid), 32'd0);
            else begin
                check($sformatf("tt_y_%0d", m - 1), 32'(ifc0.y), 32'(tt_exp[m-1]));
                check($sformatf("tt_ov_%0d", m - 1), 32'(ifc0.out_valid), 32'd1);
            end
        end
        drive0(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("tt_y_3", 32'(ifc0.y), 32'(tt_exp[3]));
        @(negedge clk);
        check("tt_drained_ov", 32'(ifc0.out_valid), 32'd0);
        check("tt_cnt",        32'(ifc0.cnt),       32'd4);

        // Backpressure: AO22 with A=B=value, C=D=0 passes the value through
        ifc0.out_ready = 1'b0;
        drive0(1'b1, 2'b10, 8'h11, 8'h11, 8'h00, 8'h00);
        #1 check("bp_ready_1", 32'(ifc0.in_ready), 32'd1);
        @(negedge clk);
        drive0(1'b1, 2'b10, 8'h22, 8'h22, 8'h00, 8'h00);
        #1 check("bp_ready_2", 32'(ifc0.in_ready), 32'd1);
        @(negedge clk);
        drive0(1'b1, 2'b10, 8'h33, 8'h33, 8'h00, 8'h00);
        #1 check("bp_ready_full", 32'(ifc0.in_ready),  32'd0);
        check("bp_y_first",       32'(ifc0.y),         32'h11);
        check("bp_ov_first",      32'(ifc0.out_valid), 32'd1);
        @(negedge clk);
        check("bp_y_hold",        32'(ifc0.y),         32'h11);
        check("bp_ready_hold",    32'(ifc0.in_ready),  32'd0);
        ifc0.out_ready = 1'b1;
        #1 check("bp_ready_comb", 32'(ifc0.in_ready),  32'd1);
        @(negedge clk);
        drive0(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("bp_y_second", 32'(ifc0.y), 32'h22);
        @(negedge clk);
        check("bp_y_third",  32'(ifc0.y), 32'h33);
        @(negedge clk);
        check("bp_drained_ov", 32'(ifc0.out_valid), 32'd0);
        check("bp_cnt",        32'(ifc0.cnt),       32'd7);

        // Full-rate stream of 10 transactions; 4-bit counter wraps 15 -> 0 -> 1
        for (int k = 1; k <= 12; k++) begin
            drive0(k <= 10, 2'b10, 8'(k), 8'(k), 8'h00, 8'h00);
            @(negedge clk);
            if (k >= 2 && k <= 11) begin
                check($sformatf("stream_y_%0d", k), 32'(ifc0.y),         32'(k - 1));
                check($sformatf("stream_ov_%0d", k), 32'(ifc0.out_valid), 32'd1);
            end
            check($sformatf("stream_cnt_%0d", k), 32'(ifc0.cnt), (k <= 2) ? 32'd7 : 32'((5 + k) % 16));
        end

        // Per-bit exhaustive on the 16-bit single-stage instance: bit i has {A,B,C,D} = i
        for (int m = 0; m < 4; m++) begin
            ifc1.in_valid = 1'b1;
            ifc1.mode     = 2'(m);
            ifc1.a        = 16'hFF00;
            ifc1.b        = 16'hF0F0;
            ifc1.c        = 16'hCCCC;
            ifc1.d        = 16'hAAAA;
            @(negedge clk);
            check($sformatf("exh_y_mode%0d", m),  32'(ifc1.y),         32'(exh_exp[m]));
            check($sformatf("exh_ov_mode%0d", m), 32'(ifc1.out_valid), 32'd1);
        end
        ifc1.in_valid = 1'b0;
        @(negedge clk);
        check("exh_drained_ov", 32'(ifc1.out_valid), 32'd0);
        check("exh_cnt",        32'(ifc1.cnt),       32'd4);

        // Mid-operation reset with a full, stalled pipeline
        ifc0.out_ready = 1'b0;
        drive0(1'b1, 2'b10, 8'h5A, 8'h5A, 8'h00, 8'h00);
        @(negedge clk);
        drive0(1'b1, 2'b10, 8'h6B, 8'h6B, 8'h00, 8'h00);
        @(negedge clk);
        drive0(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("mr_full_ready", 32'(ifc0.in_ready), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr_ov",       32'(ifc0.out_valid), 32'd0);
        check("mr_y",        32'(ifc0.y),         32'd0);
        check("mr_cnt",      32'(ifc0.cnt),       32'd0);
        check("mr_in_ready", 32'(ifc0.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ifc0.out_ready = 1'b1;
        drive0(1'b1, 2'b10, 8'h77, 8'h77, 8'h00, 8'h00);
        @(negedge clk);
        drive0(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("mr_post_ov_early", 32'(ifc0.out_valid), 32'd0);
        @(negedge clk);
        check("mr_post_y",  32'(ifc0.y),         32'h77);
        check("mr_post_ov", 32'(ifc0.out_valid), 32'd1);
        @(negedge clk);
        check("mr_post_cnt", 32'(ifc0.cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
